vstore_element_sequencer: RTL and testbench
===========================================

VSTORE_ELEMENT_SEQUENCER -- requirements
Module: vstore_element_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the element/data word width in bits.
REQ-002 SHALL have parameter NUMLANES, default 4, meaning the number of elements per data group.
REQ-003 SHALL have parameter LOG2NUMLANES, default 2, meaning log2(NUMLANES).
REQ-004 SHALL have parameter VLBITS, default 8, meaning the vector length counter width.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  store command present.
REQ-008 cmd_ready  out  1  sequencer can accept a command.
REQ-009 cmd_base  in  32  byte address of element 0.
REQ-010 cmd_stride  in  32  byte distance between consecutive elements (two's complement).
REQ-011 cmd_vl  in  VLBITS  number of elements to store.
REQ-012 cmd_size  in  2  0=byte, 1=16 bits, 2=32 bits, 3=64 bits; passed through unchanged.
REQ-013 data_valid  in  1  data group present.
REQ-014 data_ready  out  1  group buffer empty and waiting.
REQ-015 data_in  in  NUMLANES*WIDTH  elements; lane k at bits [k*WIDTH +: WIDTH].
REQ-016 data_mask  in  NUMLANES  per-lane enable; 0 = skip the element.
REQ-017 mem_en  out  1  store request valid.
REQ-018 d_address  out  32  byte address of the current element.
REQ-019 store_size  out  2  latched cmd_size.
REQ-020 write_data  out  WIDTH  current element, least-significant aligned.
REQ-021 mem_wait  in  1  memory stall; the request is held while it is high.
REQ-022 busy  out  1  high in every state except IDLE.
REQ-023 done  out  1  one-cycle completion pulse.

Function
REQ-024 SHALL implement the states IDLE, LOAD, ISSUE and DONE.
REQ-025 IDLE: cmd_ready=1; cmd_valid&&cmd_ready latches base, stride, vl and size, and clears the element count and lane index; next state is LOAD, or DONE when vl=0.
REQ-026 LOAD: data_ready=1 and mem_en=0; data_valid latches data_in and data_mask; next state is ISSUE.
REQ-027 ISSUE: the current lane's mask=1 drives mem_en=1; the element advances only when mem_en && !mem_wait.
REQ-028 ISSUE: the current lane's mask=0 drives mem_en=0; the element advances unconditionally after one cycle.
REQ-029 While mem_wait=1 with mem_en=1, d_address, write_data and store_size SHALL stay stable.
REQ-030 Each element advance SHALL increment the count and the lane index, and SHALL set address = address + stride, modulo 2^32 (wraps silently).
REQ-031 After each advance, count==vl goes to DONE; otherwise lane index wrap to 0 goes to LOAD; otherwise the state stays ISSUE.
REQ-032 A partial last group SHALL issue only its lanes below the remaining vl; its upper lanes are discarded.
REQ-033 DONE: done=1 for exactly one cycle; next state is IDLE.
REQ-034 Latency: a group accepted in cycle T gives first mem_en in T+1; with no stalls, one element per cycle.
REQ-035 cmd_valid SHALL be ignored outside IDLE, and data_valid SHALL be ignored outside LOAD.
REQ-036 The unaligned low address bits SHALL pass through unchanged; alignment is checked downstream.

Reset
REQ-037 reset SHALL force IDLE, with cmd_ready=1, data_ready=0, mem_en=0, busy=0 and done=0.
REQ-038 On reset, d_address, write_data, store_size, the count and the lane index SHALL clear to 0.
REQ-039 reset mid-operation SHALL abandon the command and buffered group on the next edge, issuing no further mem_en.
REQ-040 reset SHALL take priority over all handshakes in the same cycle.

Structure
REQ-041 A shared package vstore_pkg SHALL hold the state encodings and the size constants SIZE_B, SIZE_H, SIZE_W and SIZE_D.
REQ-042 The address accumulator and element counter SHALL be one sub-module, vstore_addr_gen, with load, advance, address and last outputs.

Verification
REQ-043 Scenario 1: base=0x100, stride=4, vl=4, size=2, mask=1111, data 0xA..0xD, no stall -> mem_en four consecutive cycles; addresses 0x100,0x104,0x108,0x10C; write_data 0xA..0xD; done one cycle after the last.
REQ-044 Scenario 2: vl=6, stride=1, size=0 -> two LOAD phases; lanes 2-3 of the 2nd group are never issued; addresses base..base+5.
REQ-045 Scenario 3: mask=0101, vl=4 -> mem_en only for lanes 0 and 2; lanes 1 and 3 take one idle cycle each; total ISSUE time is 4 cycles.
REQ-046 Scenario 4: mem_wait=1 for 3 cycles on element 1 -> outputs held constant; element 2 appears the cycle after mem_wait falls.
REQ-047 Scenario 5: vl=0 -> no data_ready, no mem_en; done pulses 1 cycle after accept. Also base=0xFFFFFFFC, stride=4, vl=2 -> second address 0x00000000.
REQ-048 Scenario 6: reset asserted during a stall in ISSUE -> next cycle IDLE, mem_en=0, cmd_ready=1; a new command then runs correctly.

Source files
------------

// File: rtl/vstore_pkg.sv
// Shared encodings for the vector store element sequencer.
package vstore_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

endpackage

// File: rtl/vstore_addr_gen.sv
// Strided byte-address accumulator plus element counter; o_last flags the
// element whose advance completes the command.
module vstore_addr_gen #(
    parameter int VLBITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [31:0]       i_base,
    input  logic [31:0]       i_stride,
    input  logic [VLBITS-1:0] i_vl,
    output logic [31:0]       o_address,
    output logic              o_last
);

    logic [31:0]       r_addr;
    logic [31:0]       r_stride;
    logic [VLBITS-1:0] r_vl;
    logic [VLBITS-1:0] r_count;
    logic [VLBITS:0]   w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr   <= '0;
            r_stride <= '0;
            r_vl     <= '0;
            r_count  <= '0;
        end else if (i_load) begin
            r_addr   <= i_base;
            r_stride <= i_stride;
            r_vl     <= i_vl;
            r_count  <= '0;
        end else if (i_advance) begin
            // 32-bit add wraps silently; negative strides are two's complement
            r_addr   <= r_addr + r_stride;
            r_count  <= r_count + {{(VLBITS-1){1'b0}}, 1'b1};
        end
    end

    assign w_cnt_nxt = {1'b0, r_count} + {{VLBITS{1'b0}}, 1'b1};
    assign o_last    = (w_cnt_nxt == {1'b0, r_vl});
    assign o_address = r_addr;

endmodule

// File: rtl/vstore_element_sequencer.sv
// Breaks a strided vector store into per-element memory requests, consuming
// NUMLANES-wide data groups and skipping masked-off lanes.
module vstore_element_sequencer
    import vstore_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int NUMLANES     = 4,
    parameter int LOG2NUMLANES = 2,
    parameter int VLBITS       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [31:0]               cmd_base,
    input  logic [31:0]               cmd_stride,
    input  logic [VLBITS-1:0]         cmd_vl,
    input  logic [1:0]                cmd_size,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic [NUMLANES*WIDTH-1:0] data_in,
    input  logic [NUMLANES-1:0]       data_mask,
    output logic                      mem_en,
    output logic [31:0]               d_address,
    output logic [1:0]                store_size,
    output logic [WIDTH-1:0]          write_data,
    input  logic                      mem_wait,
    output logic                      busy,
    output logic                      done
);

    state_t                             r_state, w_state_nxt;
    logic [NUMLANES-1:0][WIDTH-1:0]     r_data;
    logic [NUMLANES-1:0]                r_mask;
    logic [1:0]                         r_size;
    logic [LOG2NUMLANES-1:0]            r_lane;
    logic                               w_load;
    logic                               w_advance;
    logic                               w_lane_en;
    logic                               w_last;
    logic                               w_lane_wrap;

    assign w_lane_en   = r_mask[r_lane];
    assign w_load      = (r_state == ST_IDLE) && cmd_valid;
    // Masked lanes still burn one cycle so per-element timing is fixed
    assign w_advance   = (r_state == ST_ISSUE) && (!w_lane_en || !mem_wait);
    assign w_lane_wrap = (r_lane == LOG2NUMLANES'(NUMLANES - 1));

    vstore_addr_gen #(.VLBITS(VLBITS)) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_advance (w_advance),
        .i_base    (cmd_base),
        .i_stride  (cmd_stride),
        .i_vl      (cmd_vl),
        .o_address (d_address),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_mask  <= '0;
            r_size  <= '0;
            r_lane  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_size <= cmd_size;
                r_lane <= '0;
            end else if (w_advance) begin
                r_lane <= r_lane + LOG2NUMLANES'(1);
            end
            if (r_state == ST_LOAD && data_valid) begin
                r_data <= data_in;
                r_mask <= data_mask;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid)
                    w_state_nxt = (cmd_vl == '0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                if (data_valid)
                    w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Reaching vl ends the command before any upper lanes of a partial group
                if (w_advance) begin
                    if (w_last)
                        w_state_nxt = ST_DONE;
                    else if (w_lane_wrap)
                        w_state_nxt = ST_LOAD;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign cmd_ready  = (r_state == ST_IDLE);
    assign data_ready = (r_state == ST_LOAD);
    assign mem_en     = (r_state == ST_ISSUE) && w_lane_en;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign store_size = r_size;
    assign write_data = r_data[r_lane];

endmodule

// File: tb/tb_vstore_element_sequencer.sv
// Randomized scoreboard bench: driver pushes expected stores computed from
// base + index*stride; a monitor pops and compares every accepted request.
module tb_vstore_element_sequencer;

    localparam int WIDTH = 32;
    localparam int NL    = 4;
    localparam int LG    = 2;
    localparam int VLB   = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [31:0]       cmd_base = '0;
    logic [31:0]       cmd_stride = '0;
    logic [VLB-1:0]    cmd_vl = '0;
    logic [1:0]        cmd_size = '0;
    logic              data_valid = 1'b0;
    logic              data_ready;
    logic [NL*WIDTH-1:0] data_in = '0;
    logic [NL-1:0]     data_mask = '0;
    logic              mem_en;
    logic [31:0]       d_address;
    logic [1:0]        store_size;
    logic [WIDTH-1:0]  write_data;
    logic              mem_wait = 1'b0;
    logic              busy;
    logic              done;

    vstore_element_sequencer #(
        .WIDTH(WIDTH), .NUMLANES(NL), .LOG2NUMLANES(LG), .VLBITS(VLB)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_vl(cmd_vl), .cmd_size(cmd_size),
        .data_valid(data_valid), .data_ready(data_ready),
        .data_in(data_in), .data_mask(data_mask),
        .mem_en(mem_en), .d_address(d_address), .store_size(store_size),
        .write_data(write_data), .mem_wait(mem_wait),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      addr;
        logic [WIDTH-1:0] data;
        logic [1:0]       size;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   stall_mode = 0;
    int   acc_cnt = 0;
    int   acc_base = 0;
    int   stall_cycles = 0;
    int   dir_w = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares accepted requests and checks stability during stalls
    logic             pv_stall = 1'b0;
    logic [31:0]      p_addr;
    logic [WIDTH-1:0] p_data;
    logic [1:0]       p_size;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            pv_stall = 1'b0;
        end else begin
            if (pv_stall) begin
                chk("hold_mem_en", 64'(mem_en), 64'd1);
                chk("hold_addr", 64'(d_address), 64'(p_addr));
                chk("hold_data", 64'(write_data), 64'(p_data));
                chk("hold_size", 64'(store_size), 64'(p_size));
            end
            if (mem_en && !mem_wait) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_mem_en", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("addr", 64'(d_address), 64'(e.addr));
                    chk("wdata", 64'(write_data), 64'(e.data));
                    chk("size", 64'(store_size), 64'(e.size));
                end
                acc_cnt++;
            end
            if (mem_en && mem_wait) stall_cycles++;
            pv_stall = mem_en && mem_wait;
            p_addr = d_address;
            p_data = write_data;
            p_size = store_size;
        end
    end

    // Memory stall generator: 0 none, 1 random, 2 three cycles on element 1, 3 always
    always @(posedge clk) begin
        #1;
        case (stall_mode)
            1: mem_wait = ($urandom_range(0, 99) < 30);
            2: begin
                if (mem_en && (acc_cnt - acc_base) == 1 && dir_w < 3) begin
                    mem_wait = 1'b1;
                    dir_w++;
                end else begin
                    mem_wait = 1'b0;
                end
            end
            3: mem_wait = 1'b1;
            default: mem_wait = 1'b0;
        endcase
    end

    task automatic do_cmd(input logic [31:0] base, input logic [31:0] stride,
                          input logic [VLB-1:0] vl, input logic [1:0] size,
                          input logic [NL-1:0] fmask, input bit rmask);
        int w, t_acc, st0, issue_cycles, ngroups, n, e;
        logic [NL*WIDTH-1:0] dv;
        logic [NL-1:0] m;
        exp_t x;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_base = base; cmd_stride = stride; cmd_vl = vl; cmd_size = size;
        w = 0;
        while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
        if (w >= 100) chk("cmd_ready_timeout", 64'd0, 64'd1);
        t_acc = cyc; st0 = stall_cycles; acc_base = acc_cnt;
        @(negedge clk);
        // Garbage command held while busy must be ignored
        cmd_base = $urandom; cmd_stride = $urandom; cmd_vl = VLB'($urandom); cmd_size = 2'($urandom);
        issue_cycles = 0;
        ngroups = (int'(vl) + NL - 1) / NL;
        for (int g = 0; g < ngroups; g++) begin
            w = 0;
            while (!data_ready && w < 500) begin @(negedge clk); w++; end
            if (w >= 500) chk("data_ready_timeout", 64'd0, 64'd1);
            for (int k = 0; k < NL; k++) dv[k*WIDTH +: WIDTH] = $urandom;
            m = rmask ? NL'($urandom) : fmask;
            data_valid = 1'b1; data_in = dv; data_mask = m;
            for (int k = 0; k < NL; k++) begin
                e = g * NL + k;
                if (e < int'(vl) && m[k]) begin
                    x.addr = base + stride * 32'(e);
                    x.data = dv[k*WIDTH +: WIDTH];
                    x.size = size;
                    sbq.push_back(x);
                end
            end
            n = (int'(vl) - g * NL < NL) ? int'(vl) - g * NL : NL;
            issue_cycles += 1 + n;
            @(negedge clk);
            // Garbage data held outside LOAD must be ignored
            for (int k = 0; k < NL; k++) data_in[k*WIDTH +: WIDTH] = $urandom;
            data_mask = NL'($urandom);
        end
        w = 0;
        while (!done && w < 2000) begin @(negedge clk); w++; end
        if (w >= 2000) chk("done_timeout", 64'd0, 64'd1);
        cmd_valid = 1'b0; data_valid = 1'b0;
        chk("done_cycle", 64'(cyc), 64'(t_acc + issue_cycles + (stall_cycles - st0) + 1));
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        @(negedge clk);
        chk("done_pulse_len", 64'(done), 64'd0);
        chk("back_idle", 64'({cmd_ready, busy}), 64'b10);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_data_ready", 64'(data_ready), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_busy_done", 64'({busy, done}), 64'd0);
        chk("rst_outputs", 64'({d_address, store_size}), 64'd0);
        chk("rst_wdata", 64'(write_data), 64'd0);
        reset = 1'b0;

        do_cmd(32'h100, 32'd4, 8'd4, 2'd2, 4'b1111, 1'b0);
        do_cmd(32'h2000, 32'd1, 8'd6, 2'd0, 4'b1111, 1'b0);
        do_cmd(32'h300, 32'd8, 8'd4, 2'd1, 4'b0101, 1'b0);
        stall_mode = 2; dir_w = 0;
        do_cmd(32'h400, 32'd4, 8'd4, 2'd2, 4'b1111, 1'b0);
        stall_mode = 0;
        do_cmd(32'h500, 32'd4, 8'd0, 2'd3, 4'b1111, 1'b0);
        do_cmd(32'hFFFF_FFFC, 32'd4, 8'd2, 2'd2, 4'b1111, 1'b0);
        do_cmd(32'h1000, 32'hFFFF_FFF8, 8'd5, 2'd3, 4'b1111, 1'b0);

        // Reset while stalled mid-issue
        stall_mode = 3;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_base = 32'h2000; cmd_stride = 32'd8; cmd_vl = 8'd8; cmd_size = 2'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        data_valid = 1'b1; data_mask = 4'b1111; data_in = {4{$urandom}};
        @(negedge clk);
        data_valid = 1'b0;
        chk("stalled_mem_en", 64'({mem_en, mem_wait}), 64'b11);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_mem_en", 64'(mem_en), 64'd0);
        chk("midrst_state", 64'({cmd_ready, data_ready, busy, done}), 64'b1000);
        chk("midrst_addr", 64'(d_address), 64'd0);
        stall_mode = 0;
        reset = 1'b0;
        do_cmd(32'h600, 32'd2, 8'd5, 2'd1, 4'b1111, 1'b0);

        stall_mode = 1;
        for (int i = 0; i < 30; i++) begin
            logic [31:0] s;
            s = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 16)) - 32'd8;
            do_cmd($urandom, s, VLB'($urandom_range(0, 20)), 2'($urandom), 4'b1111, 1'b1);
        end
        stall_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
